meta_deframer: RTL and testbench

META_DEFRAMER -- requirements
Module: meta_deframer

---
 rtl/meta_deframer.sv | 136 +++++++++++++
 tb/tb_meta_deframer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_deframer.sv
// AXI-Stream deframer: splits a leading metadata beat (tuser=1) from the payload beats
// of each packet, and drops or counts malformed framing.
module meta_deframer #(
  parameter int DATA_WIDTH = 512,
  parameter int META_WIDTH = 356
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic                  meta_valid,
  input  logic                  meta_ready,
  output logic [META_WIDTH-1:0] meta_data,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [31:0]           pkt_count,
  output logic [15:0]           err_count
);

  localparam logic [1:0] WAIT_META = 2'd0;
  localparam logic [1:0] PASS_DATA = 2'd1;
  localparam logic [1:0] DROP      = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic                  meta_valid_reg;
  logic [META_WIDTH-1:0] meta_data_reg;
  logic                  m_tvalid_reg;
  logic [DATA_WIDTH-1:0] m_tdata_reg;
  logic                  m_tlast_reg;
  logic [31:0]           pkt_count_reg;
  logic [15:0]           err_count_reg;

  logic accept;
  logic meta_load;
  logic pay_load;
  logic err_event;
  logic pkt_event;

  always_comb begin
    s_tready = 1'b0;
    if (!rst) begin
      case (state_reg)
        WAIT_META: s_tready = !meta_valid_reg;
        PASS_DATA: s_tready = !m_tvalid_reg || m_tready;
        DROP:      s_tready = 1'b1;
        default:   s_tready = 1'b0;
      endcase
    end
  end

  assign accept    = s_tvalid && s_tready;
  assign meta_load = accept && (state_reg == WAIT_META) && s_tuser && !s_tlast;
  assign pay_load  = accept && (state_reg == PASS_DATA) && !s_tuser;
  assign pkt_event = pay_load && s_tlast;
  // Anything but a proper meta beat in WAIT_META, or a stray meta beat mid-payload.
  assign err_event = accept && (((state_reg == WAIT_META) && !(s_tuser && !s_tlast)) ||
                                ((state_reg == PASS_DATA) && s_tuser));

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      case (state_reg)
        WAIT_META: begin
          if (s_tuser && !s_tlast)
            state_next = PASS_DATA;
          else if (!s_tuser && !s_tlast)
            state_next = DROP;
        end
        PASS_DATA: if (!s_tuser && s_tlast) state_next = WAIT_META;
        DROP:      if (s_tlast) state_next = WAIT_META;
        default:   state_next = WAIT_META;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WAIT_META;
    end else begin
      state_reg <= state_next;
    end
  end

  // Metadata holding register; a new load can only happen once it is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_valid_reg <= 1'b0;
      meta_data_reg  <= '0;
    end else if (meta_load) begin
      meta_valid_reg <= 1'b1;
      meta_data_reg  <= s_tdata[META_WIDTH-1:0];
    end else if (meta_valid_reg && meta_ready) begin
      meta_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tlast_reg  <= 1'b0;
    end else if (pay_load) begin
      m_tvalid_reg <= 1'b1;
      m_tdata_reg  <= s_tdata;
      m_tlast_reg  <= s_tlast;
    end else if (m_tvalid_reg && m_tready) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_reg <= '0;
      err_count_reg <= '0;
    end else begin
      if (pkt_event)
        pkt_count_reg <= pkt_count_reg + 32'd1;
      if (err_event && (err_count_reg != 16'hFFFF))
        err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign meta_valid = meta_valid_reg;
  assign meta_data  = meta_data_reg;
  assign m_tvalid   = m_tvalid_reg;
  assign m_tdata    = m_tdata_reg;
  assign m_tlast    = m_tlast_reg;
  assign pkt_count  = pkt_count_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_meta_deframer.sv
// Bench for meta_deframer: packet-level reference model compared every cycle,
// directed framing scenarios with literal expectations, then randomized traffic.
module tb_meta_deframer;
  localparam int DW = 512;
  localparam int MW = 356;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          meta_valid;
  logic          meta_ready = 1'b1;
  logic [MW-1:0] meta_data;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [31:0]   pkt_count;
  logic [15:0]   err_count;

  meta_deframer #(.DATA_WIDTH(DW), .META_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_data(meta_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = expecting a packet's metadata, 1 = inside a packet, 2 = discarding to tlast
  int            phase = 0;
  logic          x_meta_v = 1'b0;
  logic [MW-1:0] x_meta = '0;
  logic          x_m_v = 1'b0;
  logic [DW-1:0] x_m_data = '0;
  logic          x_m_last = 1'b0;
  logic [31:0]   x_pkt = '0;
  logic [15:0]   x_err = '0;
  logic          x_rdy;
  logic          x_acc;

  assign x_rdy = rst ? 1'b0 :
                 (phase == 0) ? !x_meta_v :
                 (phase == 1) ? (!x_m_v || m_tready) : 1'b1;
  assign x_acc = s_tvalid && x_rdy;

  always @(posedge clk) begin
    if (rst) begin
      phase <= 0; x_meta_v <= 1'b0; x_meta <= '0; x_m_v <= 1'b0;
      x_m_data <= '0; x_m_last <= 1'b0; x_pkt <= '0; x_err <= '0;
    end else begin
      if (x_meta_v && meta_ready) x_meta_v <= 1'b0;
      if (x_m_v && m_tready) x_m_v <= 1'b0;
      if (x_acc) begin
        if (phase == 0) begin
          if (s_tuser && !s_tlast) begin
            x_meta_v <= 1'b1; x_meta <= s_tdata[MW-1:0]; phase <= 1;
          end else begin
            x_err <= (x_err == 16'hFFFF) ? x_err : x_err + 16'd1;
            if (!s_tuser && !s_tlast) phase <= 2;
          end
        end else if (phase == 1) begin
          if (s_tuser) begin
            x_err <= (x_err == 16'hFFFF) ? x_err : x_err + 16'd1;
          end else begin
            x_m_v <= 1'b1; x_m_data <= s_tdata; x_m_last <= s_tlast;
            if (s_tlast) begin phase <= 0; x_pkt <= x_pkt + 32'd1; end
          end
        end else if (s_tlast) begin
          phase <= 0;
        end
      end
    end
  end

  // Transfers seen at the egress ports, for order/duplication checks.
  logic [DW-1:0] got_q[$];
  logic [MW-1:0] meta_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_tready",   s_tready,   x_rdy);
      chk("meta_valid", meta_valid, x_meta_v);
      chk("meta_data",  meta_data,  x_meta);
      chk("m_tvalid",   m_tvalid,   x_m_v);
      chk("m_tdata",    m_tdata,    x_m_data);
      chk("m_tlast",    m_tlast,    x_m_last);
      chk("pkt_count",  pkt_count,  x_pkt);
      chk("err_count",  err_count,  x_err);
      if (!rst && m_tvalid && m_tready) got_q.push_back(m_tdata);
      if (!rst && meta_valid && meta_ready) meta_q.push_back(meta_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] pay(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 + i;
    return {16{w}};
  endfunction

  // Called at posedge+2; returns at posedge+2 after the beat has been accepted.
  task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
    bit acc;
    int n;
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0;
    idle(2);
    rst = 1'b0;
    got_q.delete();
    meta_q.delete();
  endtask

  logic [DW-1:0] a5_full;
  logic [MW-1:0] a5_meta;

  initial begin
    a5_full = {64{8'hA5}};
    a5_meta = a5_full[MW-1:0];
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset_pkt", pkt_count, 32'd0);
    chk("reset_mvalid", m_tvalid, 1'b0);
    @(posedge clk); #2;

    // Clean packet, everything ready.
    send(a5_full, 1'b1, 1'b0);
    send(pay(0), 1'b0, 1'b0);
    send(pay(1), 1'b0, 1'b0);
    send(pay(2), 1'b0, 1'b1);
    idle(4);
    chk("t1_pkt", pkt_count, 32'd1);
    chk("t1_err", err_count, 16'd0);
    chk("t1_beats", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("t1_order", got_q[i], pay(i));
    chk("t1_meta", (meta_q.size() > 0) ? meta_q[0] : '0, a5_meta);

    // Egress backpressure for 5 cycles after the first payload beat.
    do_reset();
    send(a5_full, 1'b1, 1'b0);
    m_tready = 1'b0;
    fork
      begin
        send(pay(10), 1'b0, 1'b0);
        send(pay(11), 1'b0, 1'b0);
        send(pay(12), 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t2_stall_ready", s_tready, 1'b0);
        chk("t2_stall_data", m_tdata, pay(10));
        repeat (3) @(posedge clk);
        #2;
        m_tready = 1'b1;
      end
    join
    idle(4);
    chk("t2_beats", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("t2_order", got_q[i], pay(10 + i));
    chk("t2_pkt", pkt_count, 32'd1);

    // Metadata consumer stalled: second packet's meta waits.
    do_reset();
    meta_ready = 1'b0;
    fork
      begin
        send(a5_full, 1'b1, 1'b0);
        send(pay(20), 1'b0, 1'b0);
        send(pay(21), 1'b0, 1'b1);
        send(~a5_full, 1'b1, 1'b0);
        send(pay(22), 1'b0, 1'b1);
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_meta_stall", s_tready, 1'b0);
        chk("t3_meta_held", meta_data, a5_meta);
        repeat (10) @(posedge clk);
        #2;
        meta_ready = 1'b1;
      end
    join
    idle(4);
    chk("t3_pkt", pkt_count, 32'd2);
    chk("t3_beats", got_q.size(), 3);
    chk("t3_metas", meta_q.size(), 2);

    // Headless payload dropped, then a valid packet.
    do_reset();
    send(pay(30), 1'b0, 1'b0);
    send(pay(31), 1'b0, 1'b0);
    send(pay(32), 1'b0, 1'b1);
    send(a5_full, 1'b1, 1'b0);
    send(pay(33), 1'b0, 1'b0);
    send(pay(34), 1'b0, 1'b1);
    idle(4);
    chk("t4_err", err_count, 16'd1);
    chk("t4_pkt", pkt_count, 32'd1);
    chk("t4_beats", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++) chk("t4_order", got_q[i], pay(33 + i));

    // Stray meta mid-payload, then a meta-only packet.
    do_reset();
    send(a5_full, 1'b1, 1'b0);
    send(pay(40), 1'b0, 1'b0);
    send(a5_full, 1'b1, 1'b0);
    send(pay(41), 1'b0, 1'b1);
    send(a5_full, 1'b1, 1'b1);
    idle(4);
    chk("t5_err", err_count, 16'd2);
    chk("t5_pkt", pkt_count, 32'd1);
    chk("t5_beats", got_q.size(), 2);
    chk("t5_metas", meta_q.size(), 1);

    // Reset while a payload beat and metadata are held.
    do_reset();
    meta_ready = 1'b0; m_tready = 1'b0;
    send(a5_full, 1'b1, 1'b0);
    send(pay(50), 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", s_tready, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_mvalid", m_tvalid, 1'b0);
    chk("t6_metavalid", meta_valid, 1'b0);
    chk("t6_pkt", pkt_count, 32'd0);
    chk("t6_err", err_count, 16'd0);
    @(posedge clk); #2;
    meta_ready = 1'b1; m_tready = 1'b1;
    got_q.delete();
    send(a5_full, 1'b1, 1'b0);
    send(pay(51), 1'b0, 1'b1);
    idle(4);
    chk("t6_pkt_after", pkt_count, 32'd1);
    chk("t6_beat", (got_q.size() > 0) ? got_q[0] : '0, pay(51));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      s_tvalid   = ($urandom_range(0, 9) < 7);
      s_tuser    = ($urandom_range(0, 99) < 20);
      s_tlast    = ($urandom_range(0, 99) < 30);
      for (int w = 0; w < DW / 32; w++) s_tdata[w*32 +: 32] = $urandom;
      meta_ready = ($urandom_range(0, 9) < 6);
      m_tready   = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #2;
    end
    rst = 1'b0; s_tvalid = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
